// File: rtl/script_pkg.sv
// Shared opcode constants, error codes and FSM state encoding for the script loader.
package script_pkg;

    localparam logic [7:0] OP_PUSH_MAX  = 8'h4b;
    localparam logic [7:0] OP_PUSHDATA1 = 8'h4c;
    localparam logic [7:0] OP_PUSHDATA2 = 8'h4d;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrOverflow = 2'd1,
        ErrTrunc    = 2'd2,
        ErrCapacity = 2'd3
    } load_err_e;

    typedef enum logic [2:0] {
        StOp,
        StPush,
        StLen1,
        StLen2L,
        StLen2H,
        StDrain,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/script_mem.sv
// Script memory: MEM_DEPTH x 8, synchronous write, asynchronous read for the interpreter PC.
module script_mem #(
    parameter  int unsigned MEM_DEPTH = 512,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/script_loader.sv
// Loads a serialized script into script_mem while validating push framing.
// Define SCRIPT_LOADER_PUSHDATA_EN to parse PUSHDATA1/PUSHDATA2 length prefixes.
module script_loader
    import script_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH = 512,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   script_len,
    output logic          load_done,
    output logic          load_error,
    output logic [1:0]    err_code,
    // Re-arm pulse from the interpreter ("release" is a reserved word).
    input  logic          load_release
);

    localparam int unsigned LenW = AW + 1;

    loader_state_e   state_q, state_d;
    logic [LenW-1:0] script_len_q, script_len_d;
    logic [15:0]     remaining_q, remaining_d;
    load_err_e       err_code_q, err_code_d;
    logic            load_done_q, load_done_d;
    logic            load_error_q, load_error_d;

    logic            hs;
    logic            mem_we;
    load_err_e       byte_err;
    logic [15:0]     cap_left;

    assign in_ready = !rst && (state_q inside {StOp, StPush, StLen1, StLen2L, StLen2H, StDrain});
    assign hs       = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        script_len_d = script_len_q;
        remaining_d  = remaining_q;
        err_code_d   = err_code_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        mem_we       = 1'b0;
        byte_err     = ErrNone;
        cap_left     = '0;

        if (state_q inside {StDone, StErr}) begin
            if (load_release) begin
                state_d      = StOp;
                script_len_d = '0;
                remaining_d  = '0;
                err_code_d   = ErrNone;
                load_done_d  = 1'b0;
                load_error_d = 1'b0;
            end
        end else if (hs) begin
            if (state_q == StDrain) begin
                if (in_last) begin
                    state_d = StErr;
                end
            end else if (script_len_q == LenW'(MEM_DEPTH)) begin
                byte_err = ErrOverflow;
            end else begin
                mem_we       = 1'b1;
                script_len_d = script_len_q + 1'b1;
                case (state_q)
                    StOp: begin
                        if (in_data != 8'h00 && in_data <= OP_PUSH_MAX) begin
                            state_d     = StPush;
                            remaining_d = {8'h00, in_data};
                        end
`ifdef SCRIPT_LOADER_PUSHDATA_EN
                        else if (in_data == OP_PUSHDATA1) begin
                            state_d = StLen1;
                        end else if (in_data == OP_PUSHDATA2) begin
                            state_d = StLen2L;
                        end
`endif
                    end
                    StPush: begin
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_d = StOp;
                        end
                    end
`ifdef SCRIPT_LOADER_PUSHDATA_EN
                    StLen1: begin
                        remaining_d = {8'h00, in_data};
                        state_d     = (in_data == 8'h00) ? StOp : StPush;
                    end
                    StLen2L: begin
                        remaining_d = {8'h00, in_data};
                        state_d     = StLen2H;
                    end
                    StLen2H: begin
                        remaining_d = {in_data, remaining_q[7:0]};
                        state_d     = (in_data == 8'h00 && remaining_q[7:0] == 8'h00) ? StOp
                                                                                       : StPush;
                    end
`endif
                    default: ;
                endcase

                // A push length becomes known exactly when we newly enter StPush.
                cap_left = 16'(MEM_DEPTH) - 16'(script_len_d);
                if (state_d == StPush && state_q != StPush && remaining_d > cap_left) begin
                    byte_err = ErrCapacity;
                end else if (in_last && state_d != StOp) begin
                    byte_err = ErrTrunc;
                end else if (in_last) begin
                    state_d = StDone;
                end
            end

            if (byte_err != ErrNone) begin
                if (err_code_q == ErrNone) begin
                    err_code_d = byte_err;
                end
                state_d = in_last ? StErr : StDrain;
            end
            if (state_d == StDone) begin
                load_done_d = 1'b1;
            end
            if (state_d == StErr) begin
                load_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StOp;
            script_len_q <= '0;
            remaining_q  <= '0;
            err_code_q   <= ErrNone;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            script_len_q <= script_len_d;
            remaining_q  <= remaining_d;
            err_code_q   <= err_code_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    script_mem #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_we),
        .wr_addr(script_len_q[AW-1:0]),
        .wr_data(in_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign script_len = script_len_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign err_code   = err_code_q;

endmodule

// File: doc/script_loader.md
# script_loader

Front-end stage that receives a serialized Bitcoin script as a byte stream, writes it into the script memory that the interpreter's PC indexes, and validates push-data framing on the fly. The interpreter is only started (`load_done`) once a complete, well-formed script is resident. It sits directly upstream of the script interpreter core and owns the script memory's write side, exposing an asynchronous read port to the interpreter.

## Interface
- `MEM_DEPTH`, 512: script memory size in bytes; also the maximum script length.
- `AW`, `$clog2(MEM_DEPTH)`: address width (derived, not overridden).
- Reset and clock: `rst` is synchronous, active-high; the clock is `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  script byte.
- `in_last`  in  1  marks the final byte of the script frame.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `rd_addr`  in  AW  interpreter read address (its PC).
- `rd_data`  out  8  `mem[rd_addr]`, combinational.
- `script_len`  out  AW+1  number of bytes stored.
- `load_done`  out  1  level; script resident and valid.
- `load_error`  out  1  level; frame rejected.
- `err_code`  out  2  0 none, 1 overflow, 2 truncated push, 3 push exceeds capacity.
- `release`  in  1  one-cycle pulse from the interpreter; re-arms the loader for the next frame.

## Operation
- A handshake occurs when `in_valid && in_ready`. Only handshaken bytes count.
- States:
  - OP: expect an opcode byte.
  - PUSH: data bytes remain.
  - LEN1: PUSHDATA1 length byte.
  - LEN2L / LEN2H: PUSHDATA2 length bytes, little-endian.
  - DRAIN: discard bytes after an error.
  - DONE.
  - ERR.
- Every handshaken byte in OP, PUSH, LEN* is written to `mem[script_len]`, then `script_len` is incremented. Length bytes are stored too; memory is an exact copy of the frame.
- Transitions from OP:
  - 0x01–0x4b → PUSH with `remaining` = byte value.
  - 0x4c → LEN1.
  - 0x4d → LEN2L.
  - Any other byte stays in OP.
- Length bytes:
  - LEN1 sets `remaining`.
  - LEN2L/LEN2H assemble a 16-bit `remaining`.
  - A length of 0 returns to OP.
- PUSH: decrement `remaining` per byte; return to OP when it reaches 0.
- Capacity check: when a push length becomes known (opcode or final length byte) and `remaining > MEM_DEPTH - script_len_after_this_byte`, set code 3.
- A byte handshaken while `script_len == MEM_DEPTH` is not written; set code 1.
- `in_last` handling:
  - In OP, or on the byte that completes a push → DONE.
  - Anywhere else (mid-push, on a push opcode with nonzero length, or on a length byte with nonzero length) → code 2, go to ERR.
- On any error without `in_last`, go to DRAIN. DRAIN accepts and discards bytes until `in_last`, then goes to ERR. The first error code is latched; later conditions do not overwrite it.
- DONE and ERR hold with `in_ready = 0` until `release`. `release` clears `script_len`, `err_code` and the flags, then returns to OP. `release` in any other state is ignored.
- `remaining` is 16 bits; there is no wrap, because the capacity check fires before the count could exceed `MEM_DEPTH`.

## Timing
- Reset values:
  - State: OP.
  - `script_len`: 0.
  - `load_done`: 0.
  - `load_error`: 0.
  - `err_code`: 0.
  - `in_ready`: 0 while `rst` is high.
  - Memory contents: not reset.
- `in_ready` is combinational: `!rst` && state ∈ {OP, PUSH, LEN1, LEN2L, LEN2H, DRAIN}. It does not depend on `in_valid`.
- Memory writes are synchronous, on the handshake edge. `rd_data` reflects the new byte from the following cycle.
- `load_done` / `load_error` rise on the clock edge after the `in_last` handshake. One byte per cycle gives full throughput.
- `release` and a new byte in the same cycle: the byte is not accepted, because `in_ready = 0` in DONE/ERR.
- `rst` mid-frame aborts immediately. The next frame starts at address 0.

## Configuration
- `SCRIPT_LOADER_PUSHDATA_EN` defined: 0x4c and 0x4d are parsed as PUSHDATA1/2 as described above.
- Undefined:
  - LEN1/LEN2L/LEN2H do not exist.
  - 0x4c and 0x4d are treated as ordinary opcodes (stay in OP).
  - Only direct pushes 0x01–0x4b are framed.

## Structure
- Shared package `script_pkg` holds:
  - constants `OP_PUSH_MAX = 8'h4b`, `OP_PUSHDATA1 = 8'h4c`, `OP_PUSHDATA2 = 8'h4d`;
  - the `load_err_e` enum (NONE, OVERFLOW, TRUNC, CAPACITY);
  - the `loader_state_e` enum.
- One sub-module, `script_mem`: `MEM_DEPTH` × 8, synchronous write, asynchronous read. The interpreter consumes it through `rd_addr`/`rd_data`.

## Test plan
- Frame 76 A9 14 ⟨20 bytes⟩ 88 AC (`in_last` on AC) → `load_done`=1, `script_len`=25, `rd_data`@2=0x14, `err_code`=0.
- Frame 03 AA BB with `in_last` on BB (one data byte short) → `load_error`=1, `err_code`=2, `script_len`=3.
- With the macro: 4C 00 51 → DONE, length 3. Then 4D 00 02 ⟨…⟩ at `MEM_DEPTH`=512 → `err_code`=3; DRAIN accepts bytes until `in_last`, then ERR.
- 513 bytes of 0x51 → `err_code`=1, `script_len`=512, `in_ready` stays 1 until `in_last`.
- Random `in_valid` gaps plus `release` after DONE, then a second frame → second script overwrites from address 0, `script_len` restarts.
- Assert `rst` after 5 bytes of a 10-byte push → outputs return to 0; a fresh frame loads correctly.
